// File: rtl/conv2d_pkg.sv
// Shared definitions for the 2-D convolution front end.
//
// Contents:
//   win_state_e         - row sequencing states: PRE_PAD, STREAM, POST_PAD
//   DEFAULT_DATA_WIDTH  - default signed sample width
//   pad_count(k)        - zero columns inserted on each side of a row, (k-1)/2
package conv2d_pkg;

  typedef enum logic [1:0] {
    PRE_PAD  = 2'd0,
    STREAM   = 2'd1,
    POST_PAD = 2'd2
  } win_state_e;

  localparam int unsigned DEFAULT_DATA_WIDTH = 16;

  function automatic int unsigned pad_count(int unsigned k);
    return (k - 1) / 2;
  endfunction

endpackage

// File: rtl/window_fill_ctrl.sv
// Sequencing for the K x K window shift array.
//
// Decides when the array shifts, whether column 0 loads zero padding, when a
// completed window is presented and which column index it carries.
//
// Optional feature: define WINDOW_ZERO_PAD_EN to frame each row with
// (K-1)/2 zero columns before and after it (PRE_PAD -> STREAM -> POST_PAD).
// Without it the sequencer sits in STREAM permanently.
//
// Ports:
//   clk          - clock, rising edge
//   rst          - asynchronous active-high reset
//   in_valid     - upstream column valid
//   in_last      - upstream column is the last of its row
//   out_ready    - downstream accepts the presented window
//   in_ready     - upstream column is consumed this cycle when in_valid is high
//   shift        - shift the array this cycle
//   pad_zero     - column 0 loads zeros instead of the upstream column
//   out_valid    - a complete window is presented
//   out_col_idx  - index of the presented window within its row
module window_fill_ctrl
  import conv2d_pkg::*;
#(
  parameter int unsigned K      = 3,
  parameter int unsigned STRIDE = 1,
  parameter int unsigned COL_W  = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic             out_ready,
  output logic             in_ready,
  output logic             shift,
  output logic             pad_zero,
  output logic             out_valid,
  output logic [COL_W-1:0] out_col_idx
);

  localparam int unsigned FillW = $clog2(K + 1);
  localparam int unsigned PhW   = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam logic [FillW-1:0] FillFull  = FillW'(K);
  localparam logic [PhW-1:0]   PhaseLast = PhW'(STRIDE - 1);

`ifdef WINDOW_ZERO_PAD_EN
  localparam int unsigned      PadW      = $clog2(K);
  localparam logic [PadW-1:0]  PadLast   = PadW'(pad_count(K) - 1);
  localparam win_state_e       InitState = PRE_PAD;
`else
  localparam win_state_e       InitState = STREAM;
`endif

  win_state_e       state_q, state_d;
  logic [FillW-1:0] fill_q, fill_d;
  logic [PhW-1:0]   phase_q, phase_d;
  logic             out_valid_q, out_valid_d;
  logic [COL_W-1:0] col_q, col_d;
  // Presented window is the final one of its row; its acceptance rewinds col.
  logic             last_win_q, last_win_d;

  logic             stream;
  logic             src_avail;
  logic             can_move;
  logic             accept;
  logic             row_end;
  logic             complete;
  logic             emit;
  logic [FillW-1:0] fill_inc;

  assign stream    = (state_q == STREAM);
  // Pad states always have a (zero) column to offer.
  assign src_avail = stream ? in_valid : 1'b1;
  assign can_move  = !out_valid_q || out_ready;
  assign shift     = src_avail && can_move && !rst;
  assign in_ready  = stream && can_move && !rst;
  assign pad_zero  = !stream;
  assign accept    = out_valid_q && out_ready;

  assign fill_inc  = (fill_q == FillFull) ? FillFull : fill_q + FillW'(1);
  assign complete  = (fill_inc == FillFull);
  assign emit      = shift && complete && (phase_q == '0);

`ifdef WINDOW_ZERO_PAD_EN
  logic [PadW-1:0] pad_cnt_q, pad_cnt_d;

  assign row_end = shift && (state_q == POST_PAD) && (pad_cnt_q == PadLast);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pad_cnt_q <= '0;
    end else begin
      pad_cnt_q <= pad_cnt_d;
    end
  end
`else
  assign row_end = shift && in_last;
`endif

  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    phase_d     = phase_q;
    out_valid_d = out_valid_q;
    col_d       = col_q;
    last_win_d  = last_win_q;
`ifdef WINDOW_ZERO_PAD_EN
    pad_cnt_d   = pad_cnt_q;
`endif

    if (accept) begin
      out_valid_d = 1'b0;
      col_d       = last_win_q ? '0 : col_q + COL_W'(1);
    end

    if (shift) begin
      fill_d      = fill_inc;
      if (complete) begin
        phase_d = (phase_q == PhaseLast) ? '0 : phase_q + PhW'(1);
      end
      out_valid_d = emit;
      last_win_d  = emit && row_end;
      if (row_end) begin
        fill_d  = '0;
        phase_d = '0;
        // With a final window still to present, its acceptance rewinds col.
        if (!emit) begin
          col_d = '0;
        end
      end
    end

`ifdef WINDOW_ZERO_PAD_EN
    unique case (state_q)
      PRE_PAD: begin
        if (shift) begin
          if (pad_cnt_q == PadLast) begin
            state_d   = STREAM;
            pad_cnt_d = '0;
          end else begin
            pad_cnt_d = pad_cnt_q + PadW'(1);
          end
        end
      end
      STREAM: begin
        if (shift && in_last) begin
          state_d = POST_PAD;
        end
      end
      POST_PAD: begin
        if (shift) begin
          if (pad_cnt_q == PadLast) begin
            state_d   = PRE_PAD;
            pad_cnt_d = '0;
          end else begin
            pad_cnt_d = pad_cnt_q + PadW'(1);
          end
        end
      end
      default: begin
        state_d   = PRE_PAD;
        pad_cnt_d = '0;
      end
    endcase
`else
    state_d = STREAM;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= InitState;
      fill_q      <= '0;
      phase_q     <= '0;
      out_valid_q <= 1'b0;
      col_q       <= '0;
      last_win_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      phase_q     <= phase_d;
      out_valid_q <= out_valid_d;
      col_q       <= col_d;
      last_win_q  <= last_win_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_col_idx = col_q;

endmodule

// File: rtl/window_reg_kxk.sv
// K x K sliding window register for streaming 2-D convolution.
//
// Columns of K samples arrive one per handshake; the array shifts them in at
// column 0 (newest) and drops column K-1. Completed windows are presented with
// a valid/ready handshake and their index within the image row.
//
// Optional feature: define WINDOW_ZERO_PAD_EN for (K-1)/2 zero columns of
// horizontal padding at both ends of every row.
//
// Ports:
//   clk          - clock, rising edge
//   Rst_window   - asynchronous active-high reset
//   in_valid     - in_col / in_last valid
//   in_ready     - column accepted this cycle when in_valid is high
//   in_col       - K lanes of DATA_WIDTH; lane r feeds window row r
//   in_last      - in_col ends the current image row
//   out_valid    - out_window holds a complete window
//   out_ready    - downstream accepts the window
//   out_window   - element (r,c) at offset (r*K+c)*DATA_WIDTH, column 0 newest
//   out_col_idx  - index of the window within its row, from 0
module window_reg_kxk
  import conv2d_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned K          = 3,
  parameter int unsigned STRIDE     = 1,
  parameter int unsigned COL_W      = 12
) (
  input  logic                             clk,
  input  logic                             Rst_window,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [K*DATA_WIDTH-1:0]          in_col,
  input  logic                             in_last,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic signed [K*K*DATA_WIDTH-1:0] out_window,
  output logic [COL_W-1:0]                 out_col_idx
);

  logic shift;
  logic pad_zero;

  window_fill_ctrl #(
    .K      (K),
    .STRIDE (STRIDE),
    .COL_W  (COL_W)
  ) u_ctrl (
    .clk         (clk),
    .rst         (Rst_window),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .out_ready   (out_ready),
    .in_ready    (in_ready),
    .shift       (shift),
    .pad_zero    (pad_zero),
    .out_valid   (out_valid),
    .out_col_idx (out_col_idx)
  );

  // win_q[r][c]: row r, column c (0 = newest).
  logic [DATA_WIDTH-1:0] win_q [K][K];

  always_ff @(posedge clk or posedge Rst_window) begin
    if (Rst_window) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else if (shift) begin
      for (int r = 0; r < K; r++) begin
        win_q[r][0] <= pad_zero ? '0 : in_col[r*DATA_WIDTH +: DATA_WIDTH];
        for (int c = 1; c < K; c++) begin
          win_q[r][c] <= win_q[r][c-1];
        end
      end
    end
  end

  always_comb begin
    out_window = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        out_window[(r*K+c)*DATA_WIDTH +: DATA_WIDTH] = win_q[r][c];
      end
    end
  end

endmodule

// File: tb/tb_window_reg_kxk.sv
// Testbench for window_reg_kxk: a cycle table for the directed handshake
// sequences, a scoreboard fed by a row-level window model for random traffic,
// and hand-written reset and stride-2 sequences. Follows WINDOW_ZERO_PAD_EN.
module tb_window_reg_kxk;

  localparam int DW = 16;
  localparam int K  = 3;
  localparam int CW = 12;
  localparam int WW = K * K * DW;
`ifdef WINDOW_ZERO_PAD_EN
  localparam int P  = (K - 1) / 2;
`else
  localparam int P  = 0;
`endif
  // Windows per row for the stride-2, 7-column row and for a 3-column row.
  localparam int N_S2_W7 = (P > 0) ? 4 : 3;
  localparam int N_S1_W3 = (P > 0) ? 3 : 1;

  logic                 clk = 1'b0;
  logic                 Rst_window;
  logic                 in_valid;
  logic [K*DW-1:0]      in_col;
  logic                 in_last;
  logic                 out_ready;
  logic                 ir1, ov1, ir2, ov2;
  logic signed [WW-1:0] win1, win2;
  logic [CW-1:0]        idx1, idx2;

  always #5 clk = ~clk;

  window_reg_kxk #(.DATA_WIDTH(DW), .K(K), .STRIDE(1), .COL_W(CW)) dut (
    .clk(clk), .Rst_window(Rst_window), .in_valid(in_valid), .in_ready(ir1),
    .in_col(in_col), .in_last(in_last), .out_valid(ov1), .out_ready(out_ready),
    .out_window(win1), .out_col_idx(idx1)
  );

  window_reg_kxk #(.DATA_WIDTH(DW), .K(K), .STRIDE(2), .COL_W(CW)) dut_s2 (
    .clk(clk), .Rst_window(Rst_window), .in_valid(in_valid), .in_ready(ir2),
    .in_col(in_col), .in_last(in_last), .out_valid(ov2), .out_ready(out_ready),
    .out_window(win2), .out_col_idx(idx2)
  );

  int checks = 0;
  int errors = 0;
  bit sel    = 1'b0;  // 0: stride-1 instance, 1: stride-2 instance
  bit mon_en = 1'b0;
  bit rnd_en = 1'b0;

  logic          ov_s, ir_s;
  logic [WW-1:0] win_s;
  logic [CW-1:0] idx_s;
  assign ov_s  = sel ? ov2  : ov1;
  assign ir_s  = sel ? ir2  : ir1;
  assign win_s = sel ? win2 : win1;
  assign idx_s = sel ? idx2 : idx1;

  typedef struct {
    logic [WW-1:0] w;
    int            idx;
  } win_rec_t;

  win_rec_t        act_q[$];
  win_rec_t        exp_q[$];
  logic [K*DW-1:0] row_q[$];

  typedef struct {
    bit iv; int val; bit last; bit ordy;
    bit e_ov; bit e_ir; int e_idx; int e0; int e1; int e2;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t v(bit iv, int val, bit last, bit ordy, bit e_ov, bit e_ir,
                             int e_idx, int e0, int e1, int e2);
    vec_t t;
    t.iv = iv; t.val = val; t.last = last; t.ordy = ordy;
    t.e_ov = e_ov; t.e_ir = e_ir; t.e_idx = e_idx; t.e0 = e0; t.e1 = e1; t.e2 = e2;
    return t;
  endfunction

  function automatic logic [K*DW-1:0] bcast(int val);
    logic [K*DW-1:0] col;
    for (int r = 0; r < K; r++) col[r*DW +: DW] = val[DW-1:0];
    return col;
  endfunction

  // Window whose column c holds value e_c in every row.
  function automatic logic [WW-1:0] rep_win(int e0, int e1, int e2);
    logic [WW-1:0] w;
    int            e[3];
    e[0] = e0; e[1] = e1; e[2] = e2;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++) w[(r*K+c)*DW +: DW] = e[c][DW-1:0];
    return w;
  endfunction

  task automatic chk(string name, logic [WW-1:0] act, logic [WW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Row model: pad the row, then every window whose newest column sits at
  // K-1, K-1+S, K-1+2S, ... of the padded sequence.
  task automatic build_expected();
    logic [K*DW-1:0] seq[$];
    int              st;
    int              m;
    st = sel ? 2 : 1;
    m  = 0;
    for (int p = 0; p < P; p++) seq.push_back('0);
    foreach (row_q[i]) seq.push_back(row_q[i]);
    for (int p = 0; p < P; p++) seq.push_back('0);
    for (int j = K - 1; j < int'(seq.size()); j += st) begin
      win_rec_t e;
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) e.w[(r*K+c)*DW +: DW] = seq[j-c][r*DW +: DW];
      e.idx = m;
      m++;
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && !Rst_window) begin
      if (ov_s && out_ready) begin
        win_rec_t a;
        a.w   = win_s;
        a.idx = int'(idx_s);
        act_q.push_back(a);
      end
      if (in_valid && ir_s) begin
        row_q.push_back(in_col);
        if (in_last) begin
          build_expected();
          row_q.delete();
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_en) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic compare_q(string tag);
    checks++;
    if (act_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s count: got %0d windows, expected %0d", tag, act_q.size(),
               exp_q.size());
    end
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      win_rec_t a, e;
      a = act_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (a.w !== e.w || a.idx != e.idx) begin
        errors++;
        $display("FAIL %s window: got %0h idx %0d, expected %0h idx %0d", tag, a.w, a.idx,
                 e.w, e.idx);
      end
    end
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    Rst_window = 1'b1;
    in_valid   = 1'b0;
    in_last    = 1'b0;
    @(posedge clk);
    #1;
    act_q.delete();
    exp_q.delete();
    row_q.delete();
    Rst_window = 1'b0;
  endtask

  task automatic send_col(logic [K*DW-1:0] col, bit last);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_col   = col;
    in_last  = last;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      ok = ir_s;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL handshake: in_ready got 0 for 200 cycles, expected 1");
    end
  endtask

  task automatic send_row(int w, bit rnd, int base);
    logic [K*DW-1:0] col;
    for (int i = 0; i < w; i++) begin
      if (rnd) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
        for (int r = 0; r < K; r++) col[r*DW +: DW] = DW'($urandom);
      end else begin
        col = bcast(base + i);
      end
      send_col(col, i == w - 1);
    end
  endtask

  task automatic drain();
    rnd_en    = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    repeat (4 * K + 4) @(posedge clk);
    #1;
  endtask

  initial begin
    Rst_window = 1'b1;
    in_valid   = 1'b0;
    in_col     = '0;
    in_last    = 1'b0;
    out_ready  = 1'b1;

`ifdef WINDOW_ZERO_PAD_EN
    // K=3, one zero column each side, row 1..4.
    tbl.push_back(v(0, 0, 0, 1,  0, 0, 0,  0, 0, 0));
    tbl.push_back(v(1, 1, 0, 1,  0, 1, 0,  0, 0, 0));
    tbl.push_back(v(1, 2, 0, 1,  0, 1, 0,  0, 0, 0));
    tbl.push_back(v(1, 3, 0, 1,  1, 1, 0,  2, 1, 0));
    tbl.push_back(v(1, 4, 1, 1,  1, 1, 1,  3, 2, 1));
    tbl.push_back(v(0, 0, 0, 1,  1, 0, 2,  4, 3, 2));
    tbl.push_back(v(0, 0, 0, 1,  1, 0, 3,  0, 4, 3));
    tbl.push_back(v(0, 0, 0, 1,  0, 1, 0,  0, 0, 0));
`else
    // Row 1..5 with a 4-cycle stall on the first window, then row 6..8 back to back.
    tbl.push_back(v(1, 1, 0, 1,  0, 1, 0,  0, 0, 0));
    tbl.push_back(v(1, 2, 0, 1,  0, 1, 0,  0, 0, 0));
    tbl.push_back(v(1, 3, 0, 1,  0, 1, 0,  0, 0, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(v(1, 4, 0, 0,  1, 0, 0,  3, 2, 1));
    tbl.push_back(v(1, 4, 0, 1,  1, 1, 0,  3, 2, 1));
    tbl.push_back(v(1, 5, 1, 1,  1, 1, 1,  4, 3, 2));
    tbl.push_back(v(1, 6, 0, 1,  1, 1, 2,  5, 4, 3));
    tbl.push_back(v(1, 7, 0, 1,  0, 1, 0,  0, 0, 0));
    tbl.push_back(v(1, 8, 1, 1,  0, 1, 0,  0, 0, 0));
    tbl.push_back(v(0, 0, 0, 1,  1, 1, 0,  8, 7, 6));
    tbl.push_back(v(0, 0, 0, 1,  0, 1, 0,  0, 0, 0));
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", WW'(ov1), '0);
    chk("reset in_ready", WW'(ir1), '0);
    chk("reset out_window", win1, '0);
    chk("reset out_col_idx", WW'(idx1), '0);
    Rst_window = 1'b0;

    foreach (tbl[i]) begin
      in_valid  = tbl[i].iv;
      in_col    = bcast(tbl[i].val);
      in_last   = tbl[i].last;
      out_ready = tbl[i].ordy;
      @(negedge clk);
      chk($sformatf("tbl[%0d] in_ready", i), WW'(ir1), WW'(tbl[i].e_ir));
      chk($sformatf("tbl[%0d] out_valid", i), WW'(ov1), WW'(tbl[i].e_ov));
      chk($sformatf("tbl[%0d] out_col_idx", i), WW'(idx1), WW'(tbl[i].e_idx));
      if (tbl[i].e_ov)
        chk($sformatf("tbl[%0d] out_window", i), win1,
            rep_win(tbl[i].e0, tbl[i].e1, tbl[i].e2));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;

    // Random rows and backpressure, stride 1.
    sel = 1'b0;
    do_reset();
    mon_en = 1'b1;
    rnd_en = 1'b1;
    for (int n = 0; n < 20; n++) send_row($urandom_range(1, 8), 1'b1, 0);
    drain();
    compare_q("rand_s1");

    // Reset two columns into a row, then a fresh 3-column row.
    do_reset();
    out_ready = 1'b1;
    send_row(2, 1'b0, 11);
    #2;
    Rst_window = 1'b1;
    #1;
    chk("midrow reset out_valid", WW'(ov1), '0);
    chk("midrow reset in_ready", WW'(ir1), '0);
    chk("midrow reset out_window", win1, '0);
    chk("midrow reset out_col_idx", WW'(idx1), '0);
    @(posedge clk);
    #1;
    act_q.delete();
    exp_q.delete();
    row_q.delete();
    Rst_window = 1'b0;
    send_row(3, 1'b0, 7);
    drain();
    chk("after reset window count", WW'(act_q.size()), WW'(N_S1_W3));
    compare_q("after_reset");

    // Stride 2: row 1..7, then random rows.
    sel = 1'b1;
    do_reset();
    out_ready = 1'b1;
    send_row(7, 1'b0, 1);
    drain();
    chk("stride2 window count", WW'(act_q.size()), WW'(N_S2_W7));
    compare_q("stride2_w7");
    rnd_en = 1'b1;
    for (int n = 0; n < 15; n++) send_row($urandom_range(1, 8), 1'b1, 0);
    drain();
    compare_q("rand_s2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
